// File: rtl/instr_queue.sv
// Instruction queue between fetch and decode: splits 64-bit fetched words into
// 32-bit instruction entries held in a circular buffer with their byte addresses.
module instr_queue #(
   parameter  int DEPTH          = 8,
   parameter  int BUS_DATA_WIDTH = 64,
   localparam int PTR_W          = $clog2(DEPTH),
   localparam int CNT_W          = PTR_W + 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [BUS_DATA_WIDTH-1:0] in_data,
   input  logic [63:0]               in_pc,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [31:0]               out_instr,
   output logic [63:0]               out_pc,
   output logic [CNT_W-1:0]          count
);

   localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - 2);

   logic [31:0]      instr_q [DEPTH];
   logic [63:0]      pc_q    [DEPTH];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d, tail_nxt;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] push_n;
   logic             push, pop, aligned;

   // Accept only when two slots are free, so an aligned word can never overflow.
   assign in_ready  = (count_q <= READY_MAX);
   assign out_valid = (count_q != '0);
   assign aligned   = ~in_pc[2];
   assign push      = in_valid & in_ready & ~flush;
   assign pop       = out_valid & out_ready & ~flush;
   assign push_n    = aligned ? CNT_W'(2) : CNT_W'(1);
   assign tail_nxt  = tail_q + PTR_W'(1);

   assign out_instr = out_valid ? instr_q[head_q] : '0;
   assign out_pc    = out_valid ? pc_q[head_q]    : '0;
   assign count     = count_q;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (pop)  head_d = head_q + PTR_W'(1);
      if (push) tail_d = tail_q + push_n[PTR_W-1:0];
      count_d = count_q + (push ? push_n : '0) - (pop ? CNT_W'(1) : '0);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            instr_q[i] <= '0;
            pc_q[i]    <= '0;
         end
      end else if (flush) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         if (push) begin
            // An odd-word address means the lower half precedes the target and is dropped.
            if (aligned) begin
               instr_q[tail_q]   <= in_data[31:0];
               pc_q[tail_q]      <= in_pc;
               instr_q[tail_nxt] <= in_data[63:32];
               pc_q[tail_nxt]    <= in_pc + 64'd4;
            end else begin
               instr_q[tail_q]   <= in_data[63:32];
               pc_q[tail_q]      <= in_pc;
            end
         end
      end
   end

endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue: queue-based scoreboard of expected
// entries, directed scenarios plus a randomized traffic run.
module tb_instr_queue;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, out_ready;
   logic        in_ready, out_valid;
   logic [63:0] in_data, in_pc, out_pc;
   logic [31:0] out_instr;
   logic [3:0]  count;

   typedef struct {
      logic [31:0] instr;
      logic [63:0] pc;
   } ent_t;

   ent_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   instr_queue #(.DEPTH(DEPTH), .BUS_DATA_WIDTH(64)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_pc(out_pc), .count(count)
   );

   always #5 clk = ~clk;

   // One clock of stimulus; the scoreboard pops and compares whatever decode consumes.
   task automatic drive(input bit v, input logic [63:0] d, input logic [63:0] pc,
                        input bit ordy, input bit fl, input bit rst_n);
      bit   m_ready, do_push, do_pop;
      ent_t e;
      in_valid  = v;
      in_data   = d;
      in_pc     = pc;
      out_ready = ordy;
      flush     = fl;
      reset     = rst_n;
      #1;
      m_ready = (DEPTH - exp_q.size()) >= 2;
      do_push = v && m_ready && !fl && rst_n;
      do_pop  = (exp_q.size() != 0) && ordy && !fl && rst_n;
      if (do_pop) begin
         n_checks++;
         if (out_instr !== exp_q[0].instr || out_pc !== exp_q[0].pc) begin
            n_fail++;
            $display("FAIL pop_data: got instr=%h pc=%h, expected instr=%h pc=%h",
                     out_instr, out_pc, exp_q[0].instr, exp_q[0].pc);
         end
      end
      @(posedge clk);
      #1;
      if (!rst_n || fl) begin
         exp_q.delete();
      end else begin
         if (do_pop) void'(exp_q.pop_front());
         if (do_push) begin
            if (pc[2] == 1'b0) begin
               e.instr = d[31:0];  e.pc = pc;         exp_q.push_back(e);
               e.instr = d[63:32]; e.pc = pc + 64'd4; exp_q.push_back(e);
            end else begin
               e.instr = d[63:32]; e.pc = pc;         exp_q.push_back(e);
            end
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      flush     = 1'b0;
      reset     = 1'b1;
   endtask

   task automatic push_word(input logic [63:0] d, input logic [63:0] pc);
      drive(1'b1, d, pc, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic pop_one();
      drive(1'b0, 64'd0, 64'd0, 1'b1, 1'b0, 1'b1);
   endtask

   task automatic do_reset();
      drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (count !== 4'd0 || out_valid !== 1'b0 || out_instr !== 32'd0 ||
          out_pc !== 64'd0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_state: count=%0d out_valid=%b instr=%h pc=%h in_ready=%b, expected 0/0/0/0/1",
                  count, out_valid, out_instr, out_pc, in_ready);
      end
   endtask

   task automatic test_aligned();
      push_word(64'h00500093_00000013, 64'h1000);
      n_checks++;
      if (count !== 4'd2 || out_instr !== 32'h00000013 || out_pc !== 64'h1000) begin
         n_fail++;
         $display("FAIL aligned_head: count=%0d instr=%h pc=%h, expected 2/00000013/1000",
                  count, out_instr, out_pc);
      end
      pop_one();
      n_checks++;
      if (count !== 4'd1 || out_instr !== 32'h00500093 || out_pc !== 64'h1004) begin
         n_fail++;
         $display("FAIL aligned_second: count=%0d instr=%h pc=%h, expected 1/00500093/1004",
                  count, out_instr, out_pc);
      end
      pop_one();
      n_checks++;
      if (count !== 4'd0 || out_valid !== 1'b0 || out_instr !== 32'd0 || out_pc !== 64'd0) begin
         n_fail++;
         $display("FAIL aligned_empty: count=%0d valid=%b instr=%h pc=%h, expected all 0",
                  count, out_valid, out_instr, out_pc);
      end
   endtask

   task automatic test_odd();
      push_word(64'hAAAAAAAA_BBBBBBBB, 64'h2004);
      n_checks++;
      if (count !== 4'd1 || out_instr !== 32'hAAAAAAAA || out_pc !== 64'h2004) begin
         n_fail++;
         $display("FAIL odd_entry: count=%0d instr=%h pc=%h, expected 1/aaaaaaaa/2004",
                  count, out_instr, out_pc);
      end
      pop_one();
      n_checks++;
      if (count !== 4'd0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL odd_drain: count=%0d valid=%b, expected 0/0", count, out_valid);
      end
      // Low address bits are carried through untouched on both halves.
      push_word(64'h22222222_11111111, 64'h6003);
      n_checks++;
      if (out_pc !== 64'h6003 || out_instr !== 32'h11111111) begin
         n_fail++;
         $display("FAIL pc_lowbits: instr=%h pc=%h, expected 11111111/6003", out_instr, out_pc);
      end
      pop_one();
      n_checks++;
      if (out_pc !== 64'h6007 || out_instr !== 32'h22222222) begin
         n_fail++;
         $display("FAIL pc_lowbits_hi: instr=%h pc=%h, expected 22222222/6007", out_instr, out_pc);
      end
      pop_one();
   endtask

   task automatic test_fill();
      for (int k = 0; k < 4; k++) begin
         push_word({32'hF0000000 + 32'(k), 32'hE0000000 + 32'(k)}, 64'h4000 + 64'(8 * k));
         n_checks++;
         if (count !== 4'(2 * (k + 1)) || in_ready !== (k < 3)) begin
            n_fail++;
            $display("FAIL fill_step%0d: count=%0d in_ready=%b, expected %0d/%b",
                     k, count, in_ready, 2 * (k + 1), (k < 3));
         end
      end
      push_word(64'hDEADDEAD_DEADDEAD, 64'h9000);
      n_checks++;
      if (count !== 4'd8) begin
         n_fail++;
         $display("FAIL fill_blocked: count=%0d, expected 8", count);
      end
      pop_one();
      n_checks++;
      if (count !== 4'd7 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL fill_seven: count=%0d in_ready=%b, expected 7/0", count, in_ready);
      end
      pop_one();
      n_checks++;
      if (count !== 4'd6 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL fill_six: count=%0d in_ready=%b, expected 6/1", count, in_ready);
      end
      while (exp_q.size() != 0) pop_one();
   endtask

   task automatic test_wrap();
      do_reset();
      push_word(64'h11111111_00000000, 64'h100);
      push_word(64'h33333333_22222222, 64'h108);
      repeat (4) pop_one();
      push_word(64'h55555555_44444444, 64'h110);
      push_word(64'h66666666_77777777, 64'h11C);
      n_checks++;
      if (count !== 4'd3) begin
         n_fail++;
         $display("FAIL wrap_setup: count=%0d, expected 3", count);
      end
      // Tail is at 7: this aligned push straddles the 7 -> 0 boundary while head pops.
      drive(1'b1, 64'h99999999_88888888, 64'h120, 1'b1, 1'b0, 1'b1);
      n_checks++;
      if (count !== 4'd4 || out_instr !== 32'h55555555 || out_pc !== 64'h114) begin
         n_fail++;
         $display("FAIL wrap_simul: count=%0d instr=%h pc=%h, expected 4/55555555/114",
                  count, out_instr, out_pc);
      end
      while (exp_q.size() != 0) pop_one();
   endtask

   task automatic test_flush();
      push_word(64'hA1A1A1A1_A0A0A0A0, 64'h500);
      push_word(64'hB1B1B1B1_B0B0B0B0, 64'h508);
      push_word(64'hC1C1C1C1_C0C0C0C0, 64'h514);
      n_checks++;
      if (count !== 4'd5) begin
         n_fail++;
         $display("FAIL flush_setup: count=%0d, expected 5", count);
      end
      drive(1'b1, 64'hD1D1D1D1_D0D0D0D0, 64'h520, 1'b1, 1'b1, 1'b1);
      n_checks++;
      if (count !== 4'd0 || out_valid !== 1'b0 || out_pc !== 64'd0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_collision: count=%0d valid=%b pc=%h in_ready=%b, expected 0/0/0/1",
                  count, out_valid, out_pc, in_ready);
      end
      push_word(64'hE1E1E1E1_E0E0E0E0, 64'h5000);
      n_checks++;
      if (count !== 4'd2 || out_pc !== 64'h5000 || out_instr !== 32'hE0E0E0E0) begin
         n_fail++;
         $display("FAIL flush_refill: count=%0d instr=%h pc=%h, expected 2/e0e0e0e0/5000",
                  count, out_instr, out_pc);
      end
      while (exp_q.size() != 0) pop_one();
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 3; k++) push_word({32'h70000000 + 32'(k), 32'h60000000 + 32'(k)}, 64'h700 + 64'(8 * k));
      n_checks++;
      if (count !== 4'd6) begin
         n_fail++;
         $display("FAIL rstmid_setup: count=%0d, expected 6", count);
      end
      drive(1'b1, 64'h12345678_9ABCDEF0, 64'h800, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (count !== 4'd0 || out_valid !== 1'b0 || out_instr !== 32'd0 ||
          out_pc !== 64'd0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_state: count=%0d valid=%b instr=%h pc=%h in_ready=%b, expected 0/0/0/0/1",
                  count, out_valid, out_instr, out_pc, in_ready);
      end
      push_word(64'h00000002_00000001, 64'h3000);
      n_checks++;
      if (out_pc !== 64'h3000 || count !== 4'd2) begin
         n_fail++;
         $display("FAIL rstmid_push: count=%0d pc=%h, expected 2/3000", count, out_pc);
      end
      while (exp_q.size() != 0) pop_one();
   endtask

   task automatic test_back_to_back();
      logic [63:0] d, pc;
      bit          v, r, f;
      for (int c = 0; c < 400; c++) begin
         d  = {$urandom, $urandom};
         pc = {$urandom, $urandom};
         v  = ($urandom_range(0, 3) != 0);
         r  = ($urandom_range(0, 2) != 0);
         f  = ($urandom_range(0, 39) == 0);
         drive(v, d, pc, r, f, 1'b1);
         n_checks++;
         if (count !== 4'(exp_q.size()) || out_valid !== (exp_q.size() != 0) ||
             in_ready !== ((DEPTH - exp_q.size()) >= 2)) begin
            n_fail++;
            $display("FAIL b2b_cycle%0d: count=%0d valid=%b in_ready=%b, expected count=%0d",
                     c, count, out_valid, in_ready, exp_q.size());
         end
      end
      while (exp_q.size() != 0) pop_one();
      n_checks++;
      if (count !== 4'd0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_drain: count=%0d valid=%b, expected 0/0", count, out_valid);
      end
   endtask

   initial begin
      reset     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_data   = '0;
      in_pc     = '0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_aligned();
      test_odd();
      test_fill();
      test_wrap();
      test_flush();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
